// File: rtl/xif_result_commit_buffer_if.sv
// Bundle of the FPU-side result input, the commit channel and the core-side
// XIF result output seen by xif_result_commit_buffer.
interface xif_result_commit_buffer_if #(
  parameter int DEPTH      = 4,
  parameter int X_ID_WIDTH = 4,
  parameter int XLEN       = 32
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                  in_valid;
  logic                  in_ready;
  logic [X_ID_WIDTH-1:0] in_id;
  logic [XLEN-1:0]       in_data;
  logic [4:0]            in_rd;
  logic                  in_we;

  logic                  commit_valid;
  logic [X_ID_WIDTH-1:0] commit_id;
  logic                  commit_kill;

  logic                  result_valid;
  logic                  result_ready;
  logic [X_ID_WIDTH-1:0] result_id;
  logic [XLEN-1:0]       result_data;
  logic [4:0]            result_rd;
  logic                  result_we;

  logic [CW-1:0]         count;
  logic                  drop_pulse;

  modport master (
    output in_valid, in_id, in_data, in_rd, in_we,
    output commit_valid, commit_id, commit_kill,
    output result_ready,
    input  in_ready, result_valid, result_id, result_data, result_rd, result_we,
    input  count, drop_pulse
  );

  modport slave (
    input  in_valid, in_id, in_data, in_rd, in_we,
    input  commit_valid, commit_id, commit_kill,
    input  result_ready,
    output in_ready, result_valid, result_id, result_data, result_rd, result_we,
    output count, drop_pulse
  );
endinterface

// File: rtl/xif_result_commit_buffer.sv
// In-order FIFO of FPU results gated by a per-id commit/kill scoreboard:
// committed heads are released to the core, killed heads are silently dropped.
module xif_result_commit_buffer #(
  parameter int DEPTH      = 4,
  parameter int X_ID_WIDTH = 4,
  parameter int XLEN       = 32
) (
  input logic                      ck,
  input logic                      rst,
  xif_result_commit_buffer_if.slave bus
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int NID = 1 << X_ID_WIDTH;

  typedef enum logic [1:0] {
    HEAD_EMPTY,
    HEAD_PENDING,
    HEAD_RELEASE,
    HEAD_DROP
  } head_state_e;

  logic [X_ID_WIDTH-1:0] id_mem   [DEPTH];
  logic [XLEN-1:0]       data_mem [DEPTH];
  logic [4:0]            rd_mem   [DEPTH];
  logic                  we_mem   [DEPTH];

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [NID-1:0]        cmt_q, cmt_d;
  logic [NID-1:0]        kill_q, kill_d;

  head_state_e           head_state;
  logic [X_ID_WIDTH-1:0] head_id;
  logic                  empty;
  logic                  push;
  logic                  pop;

  assign empty   = (count_q == '0);
  assign head_id = id_mem[rd_ptr_q];

  // Head decision uses registered scoreboard only, so a RELEASE head cannot
  // be disturbed by a commit arriving in the same cycle.
  always_comb begin
    head_state = HEAD_EMPTY;
    if (!empty) begin
      if (!cmt_q[head_id])     head_state = HEAD_PENDING;
      else if (kill_q[head_id]) head_state = HEAD_DROP;
      else                      head_state = HEAD_RELEASE;
    end
  end

  assign bus.in_ready = (count_q != CW'(DEPTH));
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = ((head_state == HEAD_RELEASE) && bus.result_ready) ||
                        (head_state == HEAD_DROP);

  assign bus.result_valid = (head_state == HEAD_RELEASE);
  assign bus.drop_pulse   = (head_state == HEAD_DROP);
  assign bus.result_id    = empty ? '0 : head_id;
  assign bus.result_data  = empty ? '0 : data_mem[rd_ptr_q];
  assign bus.result_rd    = empty ? '0 : rd_mem[rd_ptr_q];
  assign bus.result_we    = empty ? 1'b0 : we_mem[rd_ptr_q];
  assign bus.count        = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    cmt_d    = cmt_q;
    kill_d   = kill_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // First commit wins; a commit to the id being popped sees cmt already set.
    if (bus.commit_valid && !cmt_q[bus.commit_id]) begin
      cmt_d[bus.commit_id]  = 1'b1;
      kill_d[bus.commit_id] = bus.commit_kill;
    end
    if (pop) begin
      cmt_d[head_id]  = 1'b0;
      kill_d[head_id] = 1'b0;
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cmt_q    <= '0;
      kill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cmt_q    <= cmt_d;
      kill_q   <= kill_d;
    end
  end

  // Payload storage needs no reset: it is only observed when count is non-zero.
  always_ff @(posedge ck) begin
    if (push) begin
      id_mem[wr_ptr_q]   <= bus.in_id;
      data_mem[wr_ptr_q] <= bus.in_data;
      rd_mem[wr_ptr_q]   <= bus.in_rd;
      we_mem[wr_ptr_q]   <= bus.in_we;
    end
  end
endmodule

// File: tb/tb_xif_result_commit_buffer.sv
// Directed bench for xif_result_commit_buffer: inputs change and outputs are
// sampled 1 ns after each rising edge.
module tb_xif_result_commit_buffer;
  logic ck;
  logic rst;
  int   n_cmp;
  int   n_err;

  xif_result_commit_buffer_if #(.DEPTH(4), .X_ID_WIDTH(4), .XLEN(32)) bus ();

  xif_result_commit_buffer #(.DEPTH(4), .X_ID_WIDTH(4), .XLEN(32)) dut (
    .ck  (ck),
    .rst (rst),
    .bus (bus)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end else begin
      $display("  ok %s = 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic drive_push(input logic v, input logic [3:0] id, input logic [31:0] data,
                            input logic [4:0] rd);
    bus.in_valid = v;
    bus.in_id    = id;
    bus.in_data  = data;
    bus.in_rd    = rd;
    bus.in_we    = v;
  endtask

  task automatic drive_commit(input logic v, input logic [3:0] id, input logic kill);
    bus.commit_valid = v;
    bus.commit_id    = id;
    bus.commit_kill  = kill;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    drive_push(1'b0, 4'd0, 32'd0, 5'd0);
    drive_commit(1'b0, 4'd0, 1'b0);
    bus.result_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_count",  64'(bus.count), 64'd0);
    check("rst_ready",  64'(bus.in_ready), 64'd1);
    check("rst_valid",  64'(bus.result_valid), 64'd0);
    check("rst_drop",   64'(bus.drop_pulse), 64'd0);
    check("rst_data",   64'(bus.result_data), 64'd0);

    // T1: commit before push
    drive_commit(1'b1, 4'd3, 1'b0);
    tick();
    drive_commit(1'b0, 4'd0, 1'b0);
    tick();
    drive_push(1'b1, 4'd3, 32'h3F80_0000, 5'd5);
    bus.result_ready = 1'b1;
    tick();
    drive_push(1'b0, 4'd0, 32'd0, 5'd0);
    check("t1_valid", 64'(bus.result_valid), 64'd1);
    check("t1_id",    64'(bus.result_id), 64'd3);
    check("t1_data",  64'(bus.result_data), 64'h3F80_0000);
    check("t1_rd",    64'(bus.result_rd), 64'd5);
    check("t1_we",    64'(bus.result_we), 64'd1);
    check("t1_count", 64'(bus.count), 64'd1);
    tick();
    check("t1_count_after", 64'(bus.count), 64'd0);
    check("t1_valid_after", 64'(bus.result_valid), 64'd0);

    // T2: push then late commit, backpressure
    bus.result_ready = 1'b0;
    drive_push(1'b1, 4'd1, 32'h4000_0000, 5'd7);
    tick();
    drive_push(1'b0, 4'd0, 32'd0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      check("t2_pending", 64'(bus.result_valid), 64'd0);
      if (i == 2) drive_commit(1'b1, 4'd1, 1'b0);
      tick();
    end
    drive_commit(1'b0, 4'd0, 1'b0);
    check("t2_valid", 64'(bus.result_valid), 64'd1);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("t2_hold_valid", 64'(bus.result_valid), 64'd1);
      check("t2_hold_data",  64'(bus.result_data), 64'h4000_0000);
      check("t2_hold_rd",    64'(bus.result_rd), 64'd7);
      check("t2_hold_count", 64'(bus.count), 64'd1);
    end
    bus.result_ready = 1'b1;
    tick();
    check("t2_count_after", 64'(bus.count), 64'd0);

    // T3: killed head dropped, next one released
    drive_push(1'b1, 4'd2, 32'hAAAA_0002, 5'd2);
    tick();
    drive_push(1'b1, 4'd4, 32'hBBBB_0004, 5'd4);
    tick();
    drive_push(1'b0, 4'd0, 32'd0, 5'd0);
    check("t3_pending", 64'(bus.result_valid), 64'd0);
    drive_commit(1'b1, 4'd2, 1'b1);
    tick();
    check("t3_drop",       64'(bus.drop_pulse), 64'd1);
    check("t3_drop_valid", 64'(bus.result_valid), 64'd0);
    check("t3_drop_count", 64'(bus.count), 64'd2);
    drive_commit(1'b1, 4'd4, 1'b0);
    tick();
    drive_commit(1'b0, 4'd0, 1'b0);
    check("t3_drop_gone", 64'(bus.drop_pulse), 64'd0);
    check("t3_valid",     64'(bus.result_valid), 64'd1);
    check("t3_id",        64'(bus.result_id), 64'd4);
    check("t3_data",      64'(bus.result_data), 64'hBBBB_0004);
    tick();
    check("t3_count_after", 64'(bus.count), 64'd0);

    // T4: fill, reject, drain with wrap
    for (int i = 0; i < 4; i++) begin
      drive_push(1'b1, 4'(i), 32'h1000_0000 + 32'(i), 5'(i + 10));
      tick();
    end
    check("t4_full_ready", 64'(bus.in_ready), 64'd0);
    check("t4_full_count", 64'(bus.count), 64'd4);
    drive_push(1'b1, 4'd9, 32'hDEAD_BEEF, 5'd9);
    tick();
    drive_push(1'b0, 4'd0, 32'd0, 5'd0);
    check("t4_reject_count", 64'(bus.count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      drive_commit(1'b1, 4'(i), 1'b0);
      tick();
      check("t4_drain_valid", 64'(bus.result_valid), 64'd1);
      check("t4_drain_id",    64'(bus.result_id), 64'(i));
      check("t4_drain_data",  64'(bus.result_data), 64'h1000_0000 + 64'(i));
    end
    drive_commit(1'b0, 4'd0, 1'b0);
    tick();
    check("t4_empty_count", 64'(bus.count), 64'd0);
    check("t4_empty_ready", 64'(bus.in_ready), 64'd1);
    drive_commit(1'b1, 4'd5, 1'b0);
    tick();
    drive_commit(1'b0, 4'd0, 1'b0);
    drive_push(1'b1, 4'd5, 32'h5555_5555, 5'd15);
    tick();
    drive_push(1'b0, 4'd0, 32'd0, 5'd0);
    check("t4_wrap_valid", 64'(bus.result_valid), 64'd1);
    check("t4_wrap_id",    64'(bus.result_id), 64'd5);
    check("t4_wrap_data",  64'(bus.result_data), 64'h5555_5555);
    check("t4_wrap_rd",    64'(bus.result_rd), 64'd15);
    tick();
    check("t4_wrap_count", 64'(bus.count), 64'd0);

    // T5: push and commit of the same id in one cycle
    drive_push(1'b1, 4'd6, 32'h6666_0006, 5'd6);
    drive_commit(1'b1, 4'd6, 1'b0);
    tick();
    drive_push(1'b0, 4'd0, 32'd0, 5'd0);
    drive_commit(1'b0, 4'd0, 1'b0);
    check("t5_valid", 64'(bus.result_valid), 64'd1);
    check("t5_data",  64'(bus.result_data), 64'h6666_0006);
    tick();
    check("t5_count", 64'(bus.count), 64'd0);

    // T6: async reset mid-operation clears FIFO and scoreboard
    bus.result_ready = 1'b1;
    drive_push(1'b1, 4'd7, 32'h7777_0007, 5'd1);
    tick();
    drive_push(1'b1, 4'd8, 32'h8888_0008, 5'd2);
    drive_commit(1'b1, 4'd8, 1'b0);
    tick();
    drive_push(1'b1, 4'd10, 32'hAAAA_000A, 5'd3);
    drive_commit(1'b1, 4'd10, 1'b0);
    tick();
    drive_push(1'b0, 4'd0, 32'd0, 5'd0);
    drive_commit(1'b0, 4'd0, 1'b0);
    check("t6_pre_count", 64'(bus.count), 64'd3);
    check("t6_pre_valid", 64'(bus.result_valid), 64'd0);
    rst = 1'b1;
    #1;
    check("t6_rst_count", 64'(bus.count), 64'd0);
    check("t6_rst_valid", 64'(bus.result_valid), 64'd0);
    check("t6_rst_ready", 64'(bus.in_ready), 64'd1);
    #2;
    rst = 1'b0;
    tick();
    drive_push(1'b1, 4'd8, 32'h8888_1111, 5'd4);
    tick();
    drive_push(1'b0, 4'd0, 32'd0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      check("t6_no_stale_commit", 64'(bus.result_valid), 64'd0);
      check("t6_post_count",      64'(bus.count), 64'd1);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
